// File: rtl/sram_arb_pkg.sv
// Shared types and sizes for the SRAM port-0 arbiter.
// Sequencer states, owner encoding and macro geometry.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  typedef enum logic {
    OWN_WB,
    OWN_APB
  } owner_t;

  localparam int SRAM_WORDS  = 512;
  localparam int SRAM_ADDR_W = 9;
  localparam int SRAM_MASK_W = 4;

  function automatic logic is_busy(state_t s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle for the arbiter: Wishbone slave, APB slave,
// SRAM port 0 and the logic-analyser owner tap.
interface sram_port_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = 32
);
  localparam int MASK_W = DATA_W / 8;

  logic              wbs_cyc_i;
  logic              wbs_stb_i;
  logic              wbs_we_i;
  logic [MASK_W-1:0] wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [DATA_W-1:0] wbs_dat_i;
  logic              wbs_ack_o;
  logic [DATA_W-1:0] wbs_dat_o;

  logic              apb_psel;
  logic              apb_penable;
  logic              apb_pwrite;
  logic [MASK_W-1:0] apb_pstrb;
  logic [ADDR_W+1:0] apb_paddr;
  logic [DATA_W-1:0] apb_pwdata;
  logic              apb_pready;
  logic [DATA_W-1:0] apb_prdata;

  logic              sram_csb0;
  logic              sram_web0;
  logic [MASK_W-1:0] sram_wmask0;
  logic [ADDR_W-1:0] sram_addr0;
  logic [DATA_W-1:0] sram_din0;
  logic [DATA_W-1:0] sram_dout0;

  logic [1:0]        arb_owner_o;

  modport master (
    output wbs_cyc_i, wbs_stb_i, wbs_we_i,
    output wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    output apb_psel, apb_penable, apb_pwrite,
    output apb_pstrb, apb_paddr, apb_pwdata,
    input  apb_pready, apb_prdata,
    input  sram_csb0, sram_web0, sram_wmask0,
    input  sram_addr0, sram_din0,
    output sram_dout0,
    input  arb_owner_o
  );

  modport slave (
    input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
    input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    input  apb_psel, apb_penable, apb_pwrite,
    input  apb_pstrb, apb_paddr, apb_pwdata,
    output apb_pready, apb_prdata,
    output sram_csb0, sram_web0, sram_wmask0,
    output sram_addr0, sram_din0,
    input  sram_dout0,
    output arb_owner_o
  );

endinterface

// File: rtl/sram_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker.
// A tie goes to whoever was not served last.
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_wb,
  input  logic   req_apb,
  input  logic   update,
  input  owner_t upd_owner,
  output logic   any_req,
  output owner_t winner
);

  owner_t last_grant;

  // remember who was served last; APB at reset so WB wins the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= OWN_APB;
    end else if (update) begin
      last_grant <= upd_owner;
    end
  end

  // winner select from the current requests and history
  always_comb begin
    winner = OWN_WB;
    unique case (1'b1)
      req_wb && req_apb:
        winner = (last_grant == OWN_APB) ? OWN_WB : OWN_APB;
      req_apb && !req_wb:
        winner = OWN_APB;
      req_wb && !req_apb:
        winner = OWN_WB;
      default:
        winner = OWN_WB;
    endcase
  end

  assign any_req = req_wb | req_apb;

endmodule

// File: rtl/sram_port_arbiter.sv
// Port-0 owner of the 32x512 SRAM macro, shared between
// the Wishbone slave and an APB master via a 3-state sequencer.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int          ADDR_W    = SRAM_ADDR_W,
  parameter int          DATA_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000
)
(
  input logic             wb_clk_i,
  input logic             wb_rst_i,
  sram_port_arbiter_if.slave bus
);

  localparam int MASK_W = DATA_W / 8;
  localparam int HI     = ADDR_W + 2;

  state_t state;
  state_t state_n;
  owner_t owner;
  owner_t winner;
  owner_t upd_owner;

  logic wb_req;
  logic apb_req;
  logic wb_hit;
  logic any_req;
  logic take;
  logic take_miss;
  logic upd;
  logic miss;

  logic              sel_we;
  logic [MASK_W-1:0] sel_be;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  logic              csb;
  logic              web;
  logic [MASK_W-1:0] wmask;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;

  logic              resp;
  logic [DATA_W-1:0] rdata;
  logic              unused_lsb;

  assign wb_req  = bus.wbs_cyc_i & bus.wbs_stb_i;
  assign apb_req = bus.apb_psel & bus.apb_penable;

  assign wb_hit =
    bus.wbs_adr_i[31:HI] == BASE_ADDR[31:HI];

  assign unused_lsb =
    ^{bus.wbs_adr_i[1:0], bus.apb_paddr[1:0]};

  rr_arb2 u_arb (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .req_wb    (wb_req),
    .req_apb   (apb_req),
    .update    (upd),
    .upd_owner (upd_owner),
    .any_req   (any_req),
    .winner    (winner)
  );

  assign take_miss = (winner == OWN_WB) & ~wb_hit;

  // steer the winning requester's fields to the SRAM registers
  always_comb begin
    sel_we   = bus.wbs_we_i;
    sel_be   = bus.wbs_sel_i;
    sel_addr = bus.wbs_adr_i[HI-1:2];
    sel_data = bus.wbs_dat_i;
    if (winner == OWN_APB) begin
      sel_we   = bus.apb_pwrite;
      sel_be   = bus.apb_pstrb;
      sel_addr = bus.apb_paddr[HI-1:2];
      sel_data = bus.apb_pwdata;
    end
  end

  // sequencer next state and round-robin update strobe
  always_comb begin
    state_n   = state;
    take      = 1'b0;
    upd       = 1'b0;
    upd_owner = owner;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          take    = 1'b1;
          state_n = take_miss ? RESP : ISSUE;
          if (take_miss) begin
            upd       = 1'b1;
            upd_owner = OWN_WB;
          end
        end
      end
      ISSUE: begin
        state_n = RESP;
        upd     = 1'b1;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // state, owner/miss latches and registered macro inputs
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      owner <= OWN_WB;
      miss  <= 1'b0;
      csb   <= 1'b1;
      web   <= 1'b1;
      wmask <= '0;
      addr  <= '0;
      din   <= '0;
    end else begin
      state <= state_n;
      if (take) begin
        owner <= winner;
        miss  <= take_miss;
        if (!take_miss) begin
          csb   <= 1'b0;
          web   <= ~sel_we;
          wmask <= sel_we ? sel_be : '1;
          addr  <= sel_addr;
          din   <= sel_data;
        end
      end else if (state == ISSUE) begin
        csb <= 1'b1;
        web <= 1'b1;
      end
    end
  end

  assign resp  = state == RESP;
  assign rdata = miss ? '0 : bus.sram_dout0;

  assign bus.wbs_ack_o  = resp & (owner == OWN_WB);
  assign bus.apb_pready = resp & (owner == OWN_APB);
  assign bus.wbs_dat_o  = bus.wbs_ack_o  ? rdata : '0;
  assign bus.apb_prdata = bus.apb_pready ? rdata : '0;

  assign bus.sram_csb0   = csb;
  assign bus.sram_web0   = web;
  assign bus.sram_wmask0 = wmask;
  assign bus.sram_addr0  = addr;
  assign bus.sram_din0   = din;

  assign bus.arb_owner_o = {
    is_busy(state) & (owner == OWN_APB),
    is_busy(state) & (owner == OWN_WB)
  };

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: macro model, transaction
// model with scoreboard, and directed latency/data checks.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_port_arbiter_if bus ();

  sram_port_arbiter dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] sram_mem [SRAM_WORDS];
  logic [31:0] ref_mem  [SRAM_WORDS];
  logic [31:0] dout_q = 32'h0;
  assign bus.sram_dout0 = dout_q;

  // behavioural macro: inputs sampled at the edge, read data next cycle
  always @(posedge clk) begin
    if (!bus.sram_csb0) begin
      if (!bus.sram_web0) begin
        for (int b = 0; b < 4; b++)
          if (bus.sram_wmask0[b])
            sram_mem[bus.sram_addr0][8*b +: 8] <= bus.sram_din0[8*b +: 8];
      end else begin
        dout_q <= sram_mem[bus.sram_addr0];
      end
    end
  end

  typedef struct {
    bit          apb;
    bit          rd;
    logic [31:0] data;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   free_at = 0;
  bit   last_apb = 1'b1;

  function automatic exp_t mk(bit a, bit r, logic [31:0] d, int t);
    exp_t x;
    x.apb = a; x.rd = r; x.data = d; x.at = t;
    return x;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] n,
                                        logic [3:0] m);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++)
      if (m[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit wreq();
    return bus.wbs_cyc_i && bus.wbs_stb_i;
  endfunction

  function automatic bit areq();
    return bus.apb_psel && bus.apb_penable;
  endfunction

  function automatic bit win_apb();
    if (wreq() && areq()) return !last_apb;
    return areq();
  endfunction

  function automatic bit wb_hit();
    return (bus.wbs_adr_i >> 11) == (32'h3000_0000 >> 11);
  endfunction

  // transaction model: one grant per free slot, completion predicted
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      free_at  <= cyc + 1;
      last_apb <= 1'b1;
    end else if (cyc >= free_at && (wreq() || areq())) begin
      if (win_apb()) begin
        q.push_back(mk(1'b1, !bus.apb_pwrite,
                       ref_mem[bus.apb_paddr[10:2]], cyc + 2));
        if (bus.apb_pwrite)
          ref_mem[bus.apb_paddr[10:2]] <=
            merge(ref_mem[bus.apb_paddr[10:2]],
                  bus.apb_pwdata, bus.apb_pstrb);
        free_at  <= cyc + 3;
        last_apb <= 1'b1;
      end else if (!wb_hit()) begin
        q.push_back(mk(1'b0, 1'b1, 32'h0, cyc + 1));
        free_at  <= cyc + 2;
        last_apb <= 1'b0;
      end else begin
        q.push_back(mk(1'b0, !bus.wbs_we_i,
                       ref_mem[bus.wbs_adr_i[10:2]], cyc + 2));
        if (bus.wbs_we_i)
          ref_mem[bus.wbs_adr_i[10:2]] <=
            merge(ref_mem[bus.wbs_adr_i[10:2]],
                  bus.wbs_dat_i, bus.wbs_sel_i);
        free_at  <= cyc + 3;
        last_apb <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  // compare every handshake against the model
  always @(negedge clk) begin
    if (bus.wbs_ack_o || bus.apb_pready) begin
      checks++;
      if (bus.wbs_ack_o && bus.apb_pready) begin
        errors++;
        $display("FAIL both_hs cyc %0d ack=1 pready=1 want one", cyc);
      end
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_hs cyc %0d ack=%b pready=%b",
                 cyc, bus.wbs_ack_o, bus.apb_pready);
      end else begin
        e = q.pop_front();
        if (e.at != cyc || e.apb != bus.apb_pready) begin
          errors++;
          $display("FAIL hs_slot cyc %0d pready=%b want cyc %0d apb=%b",
                   cyc, bus.apb_pready, e.at, e.apb);
        end else if (e.rd) begin
          checks++;
          if (e.apb ? (bus.apb_prdata !== e.data || bus.wbs_dat_o !== 0)
                    : (bus.wbs_dat_o !== e.data || bus.apb_prdata !== 0)) begin
            errors++;
            $display("FAIL rdata cyc %0d wb=%h apb=%h want %h on apb=%b",
                     cyc, bus.wbs_dat_o, bus.apb_prdata, e.data, e.apb);
          end
        end
      end
    end else if (q.size() > 0 && q[0].at < cyc) begin
      checks++;
      errors++;
      $display("FAIL missing_hs cyc %0d none want cyc %0d apb=%b",
               cyc, q[0].at, q[0].apb);
      void'(q.pop_front());
    end
  end

  int          csb_lo = 0;
  logic [8:0]  csb_addr = '0;
  logic [3:0]  csb_mask = '0;
  logic        csb_web = 1'b1;

  // record macro selects for the directed checks
  always @(negedge clk) begin
    if (!bus.sram_csb0) begin
      csb_lo++;
      csb_addr = bus.sram_addr0;
      csb_mask = bus.sram_wmask0;
      csb_web  = bus.sram_web0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic wb_run(input bit we, input logic [31:0] adr,
                        input logic [31:0] d, input logic [3:0] sel,
                        input int n, output int t0, output int tf,
                        output int tl, output logic [31:0] rd);
    int got;
    int guard;
    got = 0; guard = 0; tf = 0; tl = 0; rd = 0;
    @(negedge clk);
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    bus.wbs_we_i = we; bus.wbs_sel_i = sel;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = d;
    t0 = cyc;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.wbs_ack_o) begin
        rd = bus.wbs_dat_o;
        if (got == 0) tf = cyc;
        tl = cyc;
        got++;
        if (got == n) begin
          bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
        end else begin
          adr += 4; d += 1;
          bus.wbs_adr_i = adr; bus.wbs_dat_i = d;
        end
      end
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL wb_timeout got %0d want %0d", got, n);
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    end
  endtask

  task automatic apb_run(input bit we, input logic [10:0] pa,
                         input logic [31:0] d, input logic [3:0] st,
                         input int n, output int t0, output int tf,
                         output int tl, output logic [31:0] rd);
    int got;
    int guard;
    got = 0; guard = 0; tf = 0; tl = 0; rd = 0;
    @(negedge clk);
    bus.apb_psel = 1'b1; bus.apb_penable = 1'b0;
    bus.apb_pwrite = we; bus.apb_paddr = pa;
    bus.apb_pwdata = d; bus.apb_pstrb = st;
    @(negedge clk);
    bus.apb_penable = 1'b1;
    t0 = cyc;
    while (got < n && guard < 200) begin
      @(negedge clk);
      guard++;
      if (bus.apb_pready) begin
        rd = bus.apb_prdata;
        if (got == 0) tf = cyc;
        tl = cyc;
        got++;
        if (got == n) begin
          bus.apb_psel = 1'b0; bus.apb_penable = 1'b0;
        end else begin
          pa += 11'd4; d += 1;
          bus.apb_paddr = pa; bus.apb_pwdata = d;
        end
      end
    end
    if (got < n) begin
      checks++; errors++;
      $display("FAIL apb_timeout got %0d want %0d", got, n);
      bus.apb_psel = 1'b0; bus.apb_penable = 1'b0;
    end
  endtask

  int w0, wf, wl, a0, af, al;
  logic [31:0] wrd, ard;

  initial begin
    for (int i = 0; i < SRAM_WORDS; i++) begin
      sram_mem[i] = 32'h0;
      ref_mem[i]  = 32'h0;
    end
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0;
    bus.wbs_sel_i = 0; bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
    bus.apb_psel = 0; bus.apb_penable = 0; bus.apb_pwrite = 0;
    bus.apb_pstrb = 0; bus.apb_paddr = 0; bus.apb_pwdata = 0;

    repeat (3) @(negedge clk);
    chk("rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    chk("rst_pready", {31'h0, bus.apb_pready}, 32'h0);
    chk("rst_wdat", bus.wbs_dat_o, 32'h0);
    chk("rst_pdat", bus.apb_prdata, 32'h0);
    chk("rst_csb", {31'h0, bus.sram_csb0}, 32'h1);
    chk("rst_web", {31'h0, bus.sram_web0}, 32'h1);
    chk("rst_mask", {28'h0, bus.sram_wmask0}, 32'h0);
    chk("rst_addr", {23'h0, bus.sram_addr0}, 32'h0);
    chk("rst_din", bus.sram_din0, 32'h0);
    chk("rst_owner", {30'h0, bus.arb_owner_o}, 32'h0);
    rst = 1'b0;

    fork
      begin
        @(negedge clk);
        wb_run(1, 32'h3000_0020, 32'h1111_1111, 4'hF, 1, w0, wf, wl, wrd);
      end
      apb_run(1, 11'h024, 32'h2222_2222, 4'hF, 1, a0, af, al, ard);
    join
    chk("tie1_wb_lat", wf - w0, 2);
    chk("tie1_apb_lat", af - a0, 5);

    wb_run(0, 32'h3000_0020, 0, 4'hF, 1, w0, wf, wl, wrd);
    chk("wb_only_lat", wf - w0, 2);
    chk("wb_only_rd", wrd, 32'h1111_1111);

    fork
      begin
        @(negedge clk);
        wb_run(0, 32'h3000_0024, 0, 4'hF, 1, w0, wf, wl, wrd);
      end
      apb_run(0, 11'h020, 0, 4'hF, 1, a0, af, al, ard);
    join
    chk("tie2_apb_lat", af - a0, 2);
    chk("tie2_wb_lat", wf - w0, 5);
    chk("tie2_apb_rd", ard, 32'h1111_1111);
    chk("tie2_wb_rd", wrd, 32'h2222_2222);

    csb_lo = 0;
    wb_run(1, 32'h3000_0010, 32'hDEAD_BEEF, 4'hF, 1, w0, wf, wl, wrd);
    chk("wr_lat", wf - w0, 2);
    chk("wr_csb_cycles", csb_lo, 1);
    chk("wr_addr", {23'h0, csb_addr}, 32'h4);
    chk("wr_web", {31'h0, csb_web}, 32'h0);
    csb_lo = 0;
    wb_run(0, 32'h3000_0010, 0, 4'h0, 1, w0, wf, wl, wrd);
    chk("rd_lat", wf - w0, 2);
    chk("rd_data", wrd, 32'hDEAD_BEEF);
    chk("rd_mask", {28'h0, csb_mask}, 32'hF);
    chk("rd_web", {31'h0, csb_web}, 32'h1);

    wb_run(1, 32'h3000_0010, 32'h0000_AB00, 4'b0010, 1, w0, wf, wl, wrd);
    apb_run(0, 11'h010, 0, 4'h0, 1, a0, af, al, ard);
    chk("apb_rd_lat", af - a0, 2);
    chk("apb_rd_data", ard, 32'hDEAD_ABEF);

    csb_lo = 0;
    wb_run(1, 32'h3000_0010, 32'hFFFF_FFFF, 4'h0, 1, w0, wf, wl, wrd);
    chk("m0_lat", wf - w0, 2);
    chk("m0_csb_cycles", csb_lo, 1);
    chk("m0_mask", {28'h0, csb_mask}, 32'h0);
    wb_run(0, 32'h3000_0010, 0, 4'hF, 1, w0, wf, wl, wrd);
    chk("m0_rd", wrd, 32'hDEAD_ABEF);

    csb_lo = 0;
    wb_run(0, 32'h3000_0800, 0, 4'hF, 1, w0, wf, wl, wrd);
    chk("miss_lat", wf - w0, 1);
    chk("miss_rd", wrd, 32'h0);
    repeat (2) @(negedge clk);
    chk("miss_csb_cycles", csb_lo, 0);

    apb_run(0, 11'h010, 0, 4'h0, 1, a0, af, al, ard);
    rst = 1'b1;
    @(negedge clk);
    chk("rresp_pready", {31'h0, bus.apb_pready}, 32'h0);
    chk("rresp_owner", {30'h0, bus.arb_owner_o}, 32'h0);
    chk("rresp_csb", {31'h0, bus.sram_csb0}, 32'h1);
    rst = 1'b0;
    wb_run(0, 32'h3000_0010, 0, 4'hF, 1, w0, wf, wl, wrd);
    chk("post_rst_lat", wf - w0, 2);
    chk("post_rst_rd", wrd, 32'hDEAD_ABEF);

    @(negedge clk);
    bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0;
    bus.wbs_adr_i = 32'h3000_0010;
    @(negedge clk);
    chk("iss_csb", {31'h0, bus.sram_csb0}, 32'h0);
    bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("iss_rst_ack", {31'h0, bus.wbs_ack_o}, 32'h0);
    chk("iss_rst_owner", {30'h0, bus.arb_owner_o}, 32'h0);
    chk("iss_rst_csb", {31'h0, bus.sram_csb0}, 32'h1);
    rst = 1'b0;

    fork
      begin
        @(negedge clk);
        wb_run(1, 32'h3000_0100, 32'hA000_0000, 4'hF, 8, w0, wf, wl, wrd);
      end
      apb_run(1, 11'h300, 32'hB000_0000, 4'hF, 8, a0, af, al, ard);
    join
    chk("alt_first_gap", (af > wf) ? af - wf : wf - af, 3);
    chk("alt_span", ((al > wl) ? al : wl) - ((af < wf) ? af : wf), 45);
    chk("alt_wb_start", wf - w0, 2);

    wb_run(0, 32'h3000_011C, 0, 4'hF, 1, w0, wf, wl, wrd);
    chk("alt_wb_rd", wrd, 32'hA000_0007);
    apb_run(0, 11'h31C, 0, 4'h0, 1, a0, af, al, ard);
    chk("alt_apb_rd", ard, 32'hB000_0007);

    repeat (3) @(negedge clk);
    chk("final_queue", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog cyc %0d want finish", cyc);
    $fatal(1, "watchdog");
  end

endmodule
